// File: rtl/astro_pkg.sv
// Shared constants and helpers for the Astro Barrier game controller.
package astro_pkg;

  // Game state encoding, also driven straight onto the state output.
  localparam int unsigned StateW = 2;
  localparam logic [StateW-1:0] StIdle       = 2'b00;
  localparam logic [StateW-1:0] StPlay       = 2'b01;
  localparam logic [StateW-1:0] StLevelClear = 2'b10;
  localparam logic [StateW-1:0] StGameOver   = 2'b11;

  localparam int unsigned ScoreW = 8;
  localparam int unsigned LevelW = 2;
  localparam int unsigned ShotsW = 4;

  // Two BCD digits saturate here.
  localparam logic [ScoreW-1:0] ScoreMax = 8'h99;

  // Add one to a two-digit BCD value, sticking at 99.
  function automatic logic [ScoreW-1:0] bcd_inc(input logic [ScoreW-1:0] s);
    logic [ScoreW-1:0] r;
    if (s >= ScoreMax) begin
      r = ScoreMax;
    end else if (s[3:0] >= 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/astro_tick_gen.sv
// Free-running game-tick divider with enable and synchronous clear.
module astro_tick_gen #(
  parameter int unsigned TICK_DIV = 2097152
) (
  input  logic board_clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Wrap is a pure function of the count so it can feed next-state logic without loops.
  assign wrap_o = en_i && (cnt_q == CntMax);

  // Count 0..TICK_DIV-1 while enabled; clear wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/astro_game_ctrl.sv
// Astro Barrier sequencing controller: game FSM, tick pacing, button arbitration,
// shot budget, target mask, level and BCD score.
module astro_game_ctrl
  import astro_pkg::*;
#(
  parameter int unsigned TICK_DIV         = 2097152,
  parameter int unsigned SHOTS_PER_LEVEL  = 8,
  parameter int unsigned NUM_TARGETS      = 3,
  parameter int unsigned NUM_LEVELS       = 4,
  parameter int unsigned CLEAR_HOLD_TICKS = 64
) (
  input  logic                   board_clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   btn_fire_i,
  input  logic                   btn_left_i,
  input  logic                   btn_right_i,
  input  logic [NUM_TARGETS-1:0] hit_valid_i,
  input  logic                   shot_done_i,
  output logic                   game_tick_o,
  output logic                   fire_cmd_o,
  output logic                   left_cmd_o,
  output logic                   right_cmd_o,
  output logic                   level_init_o,
  output logic [StateW-1:0]      state_o,
  output logic [LevelW-1:0]      level_o,
  output logic [ShotsW-1:0]      shots_left_o,
  output logic                   shot_active_o,
  output logic [NUM_TARGETS-1:0] targets_alive_o,
  output logic [ScoreW-1:0]      score_o
);

  localparam int unsigned HoldW = (CLEAR_HOLD_TICKS > 1) ? $clog2(CLEAR_HOLD_TICKS) : 1;
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(CLEAR_HOLD_TICKS - 1);
  localparam logic [LevelW-1:0] LevelLast = LevelW'(NUM_LEVELS - 1);
  localparam logic [ShotsW-1:0] ShotsInit = ShotsW'(SHOTS_PER_LEVEL);

  // Synchroniser bit order: {start, fire, left, right}.
  logic [3:0] sync1_q, sync2_q;
  logic       start_prev_q;
  logic       start_s, fire_s, left_s, right_s;
  logic       start_rise, start_fall;

  logic [StateW-1:0]      state_q, state_d;
  logic [LevelW-1:0]      level_q, level_d;
  logic [ShotsW-1:0]      shots_q, shots_d;
  logic                   active_q, active_d;
  logic [NUM_TARGETS-1:0] alive_q, alive_d;
  logic [ScoreW-1:0]      score_q, score_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic                   tick_q, tick_d;
  logic                   fire_q, fire_d;
  logic                   left_q, left_d;
  logic                   right_q, right_d;
  logic                   init_q, init_d;

  logic                   tick_en, tick_clr, tick_wrap;
  logic                   fire_ok;
  logic [NUM_TARGETS-1:0] newly_hit;

  assign start_s    = sync2_q[3];
  assign fire_s     = sync2_q[2];
  assign left_s     = sync2_q[1];
  assign right_s    = sync2_q[0];
  assign start_rise = start_s && !start_prev_q;
  assign start_fall = !start_s && start_prev_q;

  // The divider only runs while a level is live or being held; a level start restarts it.
  assign tick_en  = (state_q == StPlay) || (state_q == StLevelClear);
  assign tick_clr = (state_q == StIdle) || init_d;

  astro_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .board_clk (board_clk),
    .reset     (reset),
    .en_i      (tick_en),
    .clr_i     (tick_clr),
    .wrap_o    (tick_wrap)
  );

  // Two-flop synchronisers plus the start edge detector.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      start_prev_q <= 1'b0;
    end else begin
      sync1_q      <= {start_i, btn_fire_i, btn_left_i, btn_right_i};
      sync2_q      <= sync1_q;
      start_prev_q <= start_s;
    end
  end

  // Game FSM, arbitration and bookkeeping; exits look at the already-registered values.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    shots_d   = shots_q;
    active_d  = active_q;
    alive_d   = alive_q;
    score_d   = score_q;
    hold_d    = hold_q;
    tick_d    = 1'b0;
    fire_d    = 1'b0;
    left_d    = 1'b0;
    right_d   = 1'b0;
    init_d    = 1'b0;
    fire_ok   = 1'b0;
    newly_hit = '0;

    unique case (state_q)
      StIdle: begin
        if (start_rise) begin
          state_d  = StPlay;
          level_d  = '0;
          score_d  = '0;
          shots_d  = ShotsInit;
          alive_d  = '1;
          active_d = 1'b0;
          init_d   = 1'b1;
        end
      end
      StPlay: begin
        if (start_fall) begin
          state_d = StIdle;
        end else if (alive_q == '0) begin
          state_d = StLevelClear;
          hold_d  = '0;
        end else if ((shots_q == '0) && !active_q) begin
          state_d = StGameOver;
        end else begin
          tick_d  = tick_wrap;
          fire_ok = tick_wrap && fire_s && !active_q && (shots_q != '0);
          fire_d  = fire_ok;
          left_d  = tick_wrap && !fire_ok && left_s && !right_s;
          right_d = tick_wrap && !fire_ok && right_s && !left_s;
          if (fire_ok) begin
            shots_d  = shots_q - ShotsW'(1);
            active_d = 1'b1;
          end else if (shot_done_i) begin
            active_d = 1'b0;
          end
          newly_hit = hit_valid_i & alive_q;
          alive_d   = alive_q & ~hit_valid_i;
          for (int i = 0; i < NUM_TARGETS; i++) begin
            if (newly_hit[i]) begin
              score_d = bcd_inc(score_d);
            end
          end
        end
      end
      StLevelClear: begin
        if (tick_wrap) begin
          if (hold_q == HoldLast) begin
            if (level_q == LevelLast) begin
              state_d = StGameOver;
            end else begin
              state_d  = StPlay;
              level_d  = level_q + LevelW'(1);
              shots_d  = ShotsInit;
              alive_d  = '1;
              active_d = 1'b0;
              init_d   = 1'b1;
            end
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
      end
      StGameOver: begin
        if (!start_s) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // All game state and output strobes are registered.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      level_q  <= '0;
      shots_q  <= '0;
      active_q <= 1'b0;
      alive_q  <= '1;
      score_q  <= '0;
      hold_q   <= '0;
      tick_q   <= 1'b0;
      fire_q   <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      shots_q  <= shots_d;
      active_q <= active_d;
      alive_q  <= alive_d;
      score_q  <= score_d;
      hold_q   <= hold_d;
      tick_q   <= tick_d;
      fire_q   <= fire_d;
      left_q   <= left_d;
      right_q  <= right_d;
      init_q   <= init_d;
    end
  end

  assign game_tick_o     = tick_q;
  assign fire_cmd_o      = fire_q;
  assign left_cmd_o      = left_q;
  assign right_cmd_o     = right_q;
  assign level_init_o    = init_q;
  assign state_o         = state_q;
  assign level_o         = level_q;
  assign shots_left_o    = shots_q;
  assign shot_active_o   = active_q;
  assign targets_alive_o = alive_q;
  assign score_o         = score_q;

endmodule

// File: tb/tb_astro_game_ctrl.sv
// Directed bench for astro_game_ctrl: a small-parameter instance for sequencing and
// arbitration, and a 25-target instance to reach BCD score saturation.
module tb_astro_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, fire, left, right, sd;
  logic [2:0] hit;

  logic       game_tick, fire_cmd, left_cmd, right_cmd, level_init, active;
  logic [1:0] state, level;
  logic [3:0] shots;
  logic [2:0] alive;
  logic [7:0] score;

  logic        start_b;
  logic [24:0] hit_b;
  logic        game_tick_b, fire_cmd_b, left_cmd_b, right_cmd_b, level_init_b, active_b;
  logic [1:0]  state_b, level_b;
  logic [3:0]  shots_b;
  logic [24:0] alive_b;
  logic [7:0]  score_b;

  int n_cmp = 0;
  int n_bad = 0;
  int n, t;

  always #5 clk = ~clk;

  astro_game_ctrl #(
    .TICK_DIV(4), .SHOTS_PER_LEVEL(2), .NUM_TARGETS(3), .NUM_LEVELS(2), .CLEAR_HOLD_TICKS(2)
  ) u_dut (
    .board_clk(clk), .reset(rst), .start_i(start), .btn_fire_i(fire), .btn_left_i(left),
    .btn_right_i(right), .hit_valid_i(hit), .shot_done_i(sd), .game_tick_o(game_tick),
    .fire_cmd_o(fire_cmd), .left_cmd_o(left_cmd), .right_cmd_o(right_cmd),
    .level_init_o(level_init), .state_o(state), .level_o(level), .shots_left_o(shots),
    .shot_active_o(active), .targets_alive_o(alive), .score_o(score)
  );

  astro_game_ctrl #(
    .TICK_DIV(4), .SHOTS_PER_LEVEL(2), .NUM_TARGETS(25), .NUM_LEVELS(4), .CLEAR_HOLD_TICKS(2)
  ) u_dut_sat (
    .board_clk(clk), .reset(rst), .start_i(start_b), .btn_fire_i(1'b0), .btn_left_i(1'b0),
    .btn_right_i(1'b0), .hit_valid_i(hit_b), .shot_done_i(1'b0), .game_tick_o(game_tick_b),
    .fire_cmd_o(fire_cmd_b), .left_cmd_o(left_cmd_b), .right_cmd_o(right_cmd_b),
    .level_init_o(level_init_b), .state_o(state_b), .level_o(level_b), .shots_left_o(shots_b),
    .shot_active_o(active_b), .targets_alive_o(alive_b), .score_o(score_b)
  );

  typedef struct {
    logic       sd;
    logic       fire;
    logic       left;
    logic       right;
    logic       exp_fire;
    logic       exp_left;
    logic       exp_right;
    logic [3:0] exp_shots;
    logic       exp_active;
  } arb_vec_t;

  arb_vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Returns the number of cycles until game_tick; 16 means it never came.
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!game_tick && cnt < 16);
  endtask

  // Cycles until level_init, plus how many game_ticks were seen meanwhile.
  task automatic wait_init(output int cnt, output int ticks);
    cnt   = 0;
    ticks = 0;
    do begin
      step();
      cnt++;
      if (game_tick) ticks++;
    end while (!level_init && cnt < 40);
  endtask

  task automatic wait_init_b(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!level_init_b && cnt < 40);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            sd    fire  left  right efire eleft erght shots act
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};

    rst = 1'b1; start = 0; fire = 0; left = 0; right = 0; sd = 0; hit = '0;
    start_b = 0; hit_b = '0;
    step();
    step();
    check("rst_state", state, 2'b00);
    check("rst_level", level, 0);
    check("rst_shots", shots, 0);
    check("rst_active", active, 0);
    check("rst_alive", alive, 3'b111);
    check("rst_score", score, 0);
    check("rst_strobes", {game_tick, fire_cmd, left_cmd, right_cmd, level_init}, 0);

    // Start: level_init on the third edge after start rises, first tick 4 cycles later.
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    step();
    check("init_not_early", level_init, 0);
    step();
    check("init_at_3", level_init, 1);
    check("start_state", state, 2'b01);
    check("start_shots", shots, 2);
    check("start_alive", alive, 3'b111);
    wait_tick(n);
    check("first_tick_gap", n, 4);
    check("first_tick_cmds", {fire_cmd, left_cmd, right_cmd}, 3'b000);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].sd) begin
        sd = 1'b1;
        step();
        sd = 1'b0;
      end
      fire  = vecs[i].fire;
      left  = vecs[i].left;
      right = vecs[i].right;
      wait_tick(n);
      check($sformatf("arb%0d_gap", i), n, vecs[i].sd ? 3 : 4);
      check($sformatf("arb%0d_cmds", i), {fire_cmd, left_cmd, right_cmd},
            {vecs[i].exp_fire, vecs[i].exp_left, vecs[i].exp_right});
      check($sformatf("arb%0d_shots", i), shots, vecs[i].exp_shots);
      check($sformatf("arb%0d_active", i), active, vecs[i].exp_active);
    end
    fire = 0; left = 0; right = 0;

    // Hits: 011 scores 2, a repeat on a dead target scores nothing, last target clears.
    hit = 3'b011;
    step();
    hit = 3'b001;
    step();
    hit = 3'b000;
    check("hit_score", score, 8'h02);
    check("hit_alive", alive, 3'b100);
    hit = 3'b100;
    step();
    hit = 3'b000;
    check("clear_not_early", state, 2'b01);
    check("clear_score", score, 8'h03);
    step();
    check("clear_state", state, 2'b10);
    wait_init(n, t);
    check("clear_hold_len", n, 8);
    check("clear_no_ticks", t, 0);
    check("lvl1_level", level, 1);
    check("lvl1_shots", shots, 2);
    check("lvl1_alive", alive, 3'b111);
    check("lvl1_state", state, 2'b01);

    // Game over: two shots, both missing.
    fire = 1'b1;
    wait_tick(n);
    check("go_fire1", {fire_cmd, shots}, {1'b1, 4'd1});
    fire = 1'b0;
    sd = 1'b1;
    step();
    sd = 1'b0;
    fire = 1'b1;
    wait_tick(n);
    check("go_fire2", {fire_cmd, shots}, {1'b1, 4'd0});
    fire = 1'b0;
    sd = 1'b1;
    step();
    sd = 1'b0;
    check("go_not_early", {active, state}, {1'b0, 2'b01});
    step();
    check("go_state", state, 2'b11);
    start = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (state != 2'b00 && n < 10);
    check("go_to_idle_lat", n, 3);
    check("idle_score_held", score, 8'h03);

    // Final shot that kills the last target counts as a clear, not game over.
    start = 1'b1;
    wait_init(n, t);
    check("restart_lat", n, 3);
    check("restart_regs", {score, level, shots}, {8'h00, 2'd0, 4'd2});
    hit = 3'b011;
    step();
    hit = 3'b000;
    fire = 1'b1;
    wait_tick(n);
    check("ls_fire1", fire_cmd, 1);
    fire = 1'b0;
    sd = 1'b1;
    step();
    sd = 1'b0;
    fire = 1'b1;
    wait_tick(n);
    check("ls_fire2", {fire_cmd, shots}, {1'b1, 4'd0});
    fire = 1'b0;
    hit = 3'b100;
    sd = 1'b1;
    step();
    hit = 3'b000;
    sd = 1'b0;
    check("ls_regs", {alive, active, shots, state}, {3'b000, 1'b0, 4'd0, 2'b01});
    step();
    check("ls_state_clear", state, 2'b10);
    wait_init(n, t);
    check("ls_next_level", level, 1);

    // Dropping start mid-PLAY returns to IDLE after the synchroniser delay.
    start = 1'b0;
    step();
    step();
    check("drop_not_early", state, 2'b01);
    step();
    check("drop_idle", state, 2'b00);

    // Asynchronous reset mid-PLAY, checked before any further clock edge.
    start = 1'b1;
    wait_init(n, t);
    hit = 3'b001;
    step();
    hit = 3'b000;
    fire = 1'b1;
    wait_tick(n);
    fire = 1'b0;
    check("pre_rst_regs", {score, shots, game_tick}, {8'h01, 4'd1, 1'b1});
    #3;
    rst = 1'b1;
    #1;
    check("arst_state", state, 2'b00);
    check("arst_shots", shots, 0);
    check("arst_active", active, 0);
    check("arst_alive", alive, 3'b111);
    check("arst_score", score, 0);
    check("arst_strobes", {game_tick, fire_cmd, left_cmd, right_cmd, level_init}, 0);
    start = 1'b0;
    #2;
    rst = 1'b0;
    step();

    // Saturation: 25 targets per level, 4 levels, so 25+25+25+23 = 98, then +2 sticks at 99.
    start_b = 1'b1;
    wait_init_b(n);
    check("b_init", level_init_b, 1);
    for (int l = 0; l < 3; l++) begin
      hit_b = '1;
      step();
      hit_b = '0;
      check($sformatf("b_score_l%0d", l), score_b, (l == 0) ? 8'h25 : (l == 1) ? 8'h50 : 8'h75);
      wait_init_b(n);
      check($sformatf("b_level_l%0d", l), {level_init_b, level_b}, {1'b1, 2'(l + 1)});
    end
    hit_b = 25'h07F_FFFF;
    step();
    hit_b = '0;
    check("b_score_98", score_b, 8'h98);
    hit_b = 25'h180_0000;
    step();
    hit_b = '0;
    check("b_score_sat", score_b, 8'h99);
    check("b_alive_zero", alive_b, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (state_b != 2'b11 && n < 40);
    check("b_last_level_over", state_b, 2'b11);
    check("b_score_final", score_b, 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
